// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared frame-checker states, parity constants and parameter ranges
package uart_rx_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;
endpackage

// File: rtl/uart_sat_counter.sv
// uart_sat_counter: saturating up-counter with clear taking priority over increment
module uart_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/uart_frame_checker.sv
// uart_frame_checker: walks start/data/parity/stop per sample, flags errors, counts bad frames
module uart_frame_checker
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SampleValid,
  input  logic                  SampledBit,
  input  logic                  ParEn,
  input  logic                  ParType,
  input  logic                  ClrCount,
  output logic                  Busy,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataValid,
  output logic                  FrameDone,
  output logic                  StartError,
  output logic                  ParityError,
  output logic                  StopError,
  output logic [CNT_WIDTH-1:0]  ErrorCount
);
  localparam int CW = $clog2(DATA_WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic par_en, par_type, stop_flag;
  logic last_data, last_stop, stop_err, inc;
  assign Busy = state != IDLE;
  assign last_data = cnt == CW'(DATA_WIDTH - 1);
  assign last_stop = cnt == CW'(STOP_BITS - 1);
  assign stop_err = stop_flag | ~SampledBit;
  // Count is updated on the same edge that raises FrameDone so both appear together.
  assign inc = SampleValid && ((state == IDLE && SampledBit) ||
               (state == STOP && last_stop && (ParityError || stop_err)));
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      shift <= '0;
      par_en <= 1'b0;
      par_type <= 1'b0;
      stop_flag <= 1'b0;
      DataOut <= '0;
      DataValid <= 1'b0;
      FrameDone <= 1'b0;
      StartError <= 1'b0;
      ParityError <= 1'b0;
      StopError <= 1'b0;
    end else begin
      DataValid <= 1'b0;
      FrameDone <= 1'b0;
      if (SampleValid) begin
        unique case (state)
          IDLE: begin
            par_en <= ParEn;
            par_type <= ParType;
            stop_flag <= 1'b0;
            StartError <= SampledBit;
            ParityError <= 1'b0;
            StopError <= 1'b0;
            cnt <= '0;
            FrameDone <= SampledBit;
            state <= SampledBit ? IDLE : DATA;
          end
          DATA: begin
            shift <= {SampledBit, shift[DATA_WIDTH-1:1]};
            cnt <= last_data ? '0 : cnt + 1'b1;
            state <= !last_data ? DATA : par_en ? PARITY : STOP;
          end
          PARITY: begin
            ParityError <= SampledBit != (^shift ^ (par_type == PAR_ODD));
            cnt <= '0;
            state <= STOP;
          end
          STOP: begin
            stop_flag <= stop_err;
            cnt <= cnt + 1'b1;
            if (last_stop) begin
              StopError <= stop_err;
              DataOut <= shift;
              FrameDone <= 1'b1;
              DataValid <= !ParityError && !stop_err;
              cnt <= '0;
              state <= IDLE;
            end
          end
        endcase
      end
    end
  end
  uart_sat_counter #(.W(CNT_WIDTH)) u_err_cnt (
    .clk(CLK),
    .rst(RST),
    .inc(inc),
    .clr(ClrCount),
    .count(ErrorCount)
  );
endmodule

// File: tb/tb_uart_frame_checker.sv
// tb_uart_frame_checker: directed frame vectors plus counter, reset and two-stop-bit sequences
module tb_uart_frame_checker;
  logic clk = 1'b0, rst, sv_a, sv_b, sbit, par_en, par_type, clr;
  logic busy_a, dv_a, fd_a, se_a, pe_a, ste_a;
  logic busy_b, dv_b, fd_b, se_b, pe_b, ste_b;
  logic [7:0] dout_a, dout_b, cnt_a;
  logic [1:0] cnt_b;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  uart_frame_checker #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(8)) dut_a (
    .CLK(clk), .RST(rst), .SampleValid(sv_a), .SampledBit(sbit), .ParEn(par_en),
    .ParType(par_type), .ClrCount(clr), .Busy(busy_a), .DataOut(dout_a), .DataValid(dv_a),
    .FrameDone(fd_a), .StartError(se_a), .ParityError(pe_a), .StopError(ste_a), .ErrorCount(cnt_a)
  );
  uart_frame_checker #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(2)) dut_b (
    .CLK(clk), .RST(rst), .SampleValid(sv_b), .SampledBit(sbit), .ParEn(par_en),
    .ParType(par_type), .ClrCount(clr), .Busy(busy_b), .DataOut(dout_b), .DataValid(dv_b),
    .FrameDone(fd_b), .StartError(se_b), .ParityError(pe_b), .StopError(ste_b), .ErrorCount(cnt_b)
  );
  typedef struct {
    logic pe, pt;
    logic [7:0] d;
    logic p, s, fs;
    logic [7:0] dout;
    logic dv, se, perr, ste;
    logic [7:0] cnt;
  } vec_t;
  vec_t v[7];
  logic [7:0] bcnt[6];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_bit(input logic which, input logic b, input logic c);
    @(negedge clk);
    sbit = b;
    sv_a = !which;
    sv_b = which;
    clr = c;
    @(negedge clk);
    sv_a = 1'b0;
    sv_b = 1'b0;
    clr = 1'b0;
  endtask
  // Parity settings are flipped right after the start sample; the DUT must use the latched ones.
  task automatic send_frame(input logic which, input logic pe, input logic pt, input logic [7:0] d,
                            input logic p, input logic [1:0] stops, input int nstop,
                            input logic fs, input logic c);
    par_en = pe;
    par_type = pt;
    if (fs) send_bit(which, 1'b1, c);
    else begin
      send_bit(which, 1'b0, 1'b0);
      par_en = ~pe;
      par_type = ~pt;
      for (int i = 0; i < 8; i++) send_bit(which, d[i], 1'b0);
      if (pe) send_bit(which, p, 1'b0);
      for (int i = 0; i < nstop; i++) send_bit(which, stops[i], c && i == nstop - 1);
    end
  endtask
  initial begin
    v[0] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    v[1] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    v[2] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    v[3] = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    v[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
    v[5] = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3};
    v[6] = '{1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4};
    bcnt = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd0};
    rst = 1'b1;
    {sv_a, sv_b, sbit, par_en, par_type, clr} = '0;
    repeat (3) @(negedge clk);
    check("reset_a", {busy_a, dout_a, dv_a, fd_a, se_a, pe_a, ste_a, cnt_a}, 0);
    check("reset_b", {busy_b, dout_b, dv_b, fd_b, se_b, pe_b, ste_b, cnt_b}, 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send_frame(1'b0, v[i].pe, v[i].pt, v[i].d, v[i].p, {1'b1, v[i].s}, 1, v[i].fs, 1'b0);
      check($sformatf("v%0d_dout", i), dout_a, v[i].dout);
      check($sformatf("v%0d_dv", i), dv_a, v[i].dv);
      check($sformatf("v%0d_fd", i), fd_a, 1);
      check($sformatf("v%0d_serr", i), se_a, v[i].se);
      check($sformatf("v%0d_perr", i), pe_a, v[i].perr);
      check($sformatf("v%0d_sterr", i), ste_a, v[i].ste);
      check($sformatf("v%0d_cnt", i), cnt_a, v[i].cnt);
      check($sformatf("v%0d_busy", i), busy_a, 0);
      @(negedge clk);
      check($sformatf("v%0d_pulse_end", i), {fd_a, dv_a}, 0);
      check($sformatf("v%0d_dout_hold", i), dout_a, v[i].dout);
    end
    par_en = 1'b0;
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, i[0], 1'b0);
    check("mid_busy", busy_a, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_a", {busy_a, dout_a, dv_a, fd_a, se_a, pe_a, ste_a, cnt_a}, 0);
    send_frame(1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 2'b11, 1, 1'b0, 1'b0);
    check("post_rst_dout", dout_a, 8'h5A);
    check("post_rst_dv", {dv_a, fd_a, se_a, pe_a, ste_a}, 5'b11000);
    check("post_rst_cnt", cnt_a, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) send_frame(1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 2'b01, 2, 1'b0, 1'b0);
      else if (i == 2) send_frame(1'b1, 1'b0, 1'b0, 8'h81, 1'b0, 2'b00, 2, 1'b0, 1'b0);
      else send_frame(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 2, 1'b1, i == 5);
      check($sformatf("b%0d_cnt", i), cnt_b, bcnt[i][1:0]);
      check($sformatf("b%0d_fd", i), {fd_b, dv_b, busy_b}, 3'b100);
    end
    check("b0_never_valid_a", cnt_a, 0);
    send_frame(1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 2'b11, 2, 1'b0, 1'b0);
    check("b_good_dout", dout_b, 8'h3C);
    check("b_good_flags", {dv_b, fd_b, se_b, pe_b, ste_b}, 5'b11000);
    check("b_good_cnt", cnt_b, 0);
    send_frame(1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 2'b01, 2, 1'b0, 1'b0);
    check("b_stop2_err", {dv_b, fd_b, ste_b}, 3'b011);
    check("b_stop2_cnt", cnt_b, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_frame_checker.md
Name: uart_frame_checker

Overview:
Parametrised frame checker for the UART receive path. It consumes one sampled bit per SampleValid pulse from the data sampler and walks the frame: start, DATA_WIDTH data bits LSB-first, optional parity, then STOP_BITS stop bits. It reports start, parity and stop errors, delivers the assembled data word, and keeps a saturating count of errored frames. It sits between the sampler and the RX FSM/output register, replacing separate per-field check blocks.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9
STOP_BITS, 1, stop bits checked per frame; legal values 1 or 2
CNT_WIDTH, 8, width of the errored-frame counter

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
SampleValid  input  1  one-cycle pulse; SampledBit holds a valid bit sample
SampledBit  input  1  majority-sampled line value
ParEn  input  1  1 = frame carries a parity bit
ParType  input  1  0 = even, 1 = odd
ClrCount  input  1  synchronous clear of ErrorCount
Busy  output  1  1 while a frame is in progress (not IDLE)
DataOut  output  DATA_WIDTH  last assembled data word
DataValid  output  1  one-cycle pulse: frame complete with no errors
FrameDone  output  1  one-cycle pulse: frame ended, good or bad
StartError  output  1  start sample was 1
ParityError  output  1  parity mismatch on last frame
StopError  output  1  any stop sample was 0
ErrorCount  output  CNT_WIDTH  saturating count of errored frames

Behaviour:
- Reset (RST=1 at a CLK edge, overriding all else): state IDLE; bit counter 0; shift register 0; all outputs 0, including ErrorCount.
- Inputs are acted on only in cycles with SampleValid=1. Otherwise the FSM holds, and DataValid/FrameDone are 0.
- States and transitions:
  - IDLE: a sample is the start bit. ParEn/ParType are latched here; later changes are ignored until the next frame.
    - StartError <= SampledBit. ParityError and StopError are cleared.
    - Sample 0: go to DATA, bit counter = 0.
    - Sample 1: pulse FrameDone, count an error, stay IDLE (false-start rejection).
  - DATA: shift SampledBit into bit [DATA_WIDTH-1], shifting the register right so the LSB arrives first. Increment the counter.
    - On sample DATA_WIDTH-1: go to PARITY if the latched ParEn=1, else STOP.
  - PARITY: expected parity = XOR of the data bits, inverted when ParType=1. ParityError <= (SampledBit != expected). Go to STOP, counter = 0.
  - STOP: any 0 sample sets an internal stop flag.
    - On sample STOP_BITS-1: StopError <= flag OR (SampledBit==0). Go to IDLE. FrameDone=1 next cycle. DataOut <= shift register.
    - DataValid=1 only if ParityError and StopError for this frame are both 0.
- Latency: FrameDone, DataValid, DataOut and the error flags are registered and appear on the cycle after the completing SampleValid edge.
- DataOut updates at every frame end, including errored frames; it is stable otherwise.
- Error flags hold their value until the next start sample.
- ErrorCount:
  - Increments by 1 on each FrameDone with any error flag set.
  - Saturates at 2^CNT_WIDTH-1; no wrap.
  - ClrCount in the same cycle as an increment: clear wins, result 0.
- Busy = (state != IDLE).
- Reset mid-frame aborts the frame: no FrameDone, no count change other than the reset to 0.

Decomposition:
- Shared package uart_rx_pkg holds:
  - state enum (IDLE, DATA, PARITY, STOP)
  - parity-type constants PAR_EVEN=0, PAR_ODD=1
  - legal parameter ranges
- One natural sub-module: uart_sat_counter, a saturating counter with increment, clear-priority and CNT_WIDTH parameter, used for ErrorCount.
- Everything else stays in one FSM.

Test Plan:
1. DATA_WIDTH=8, ParEn=1, ParType=0. Samples 0, then 1,0,1,0,0,1,0,1 (0xA5), parity 0, stop 1 -> DataOut=0xA5, DataValid=1, FrameDone=1, all errors 0, ErrorCount=0.
2. Same frame with parity bit 1 -> ParityError=1, DataValid=0, FrameDone=1, DataOut=0xA5, ErrorCount=1.
3. STOP_BITS=2, ParEn=0, data 0x3C, stop samples 1 then 0 -> StopError=1, DataValid=0, ErrorCount increments by 1.
4. Start sample 1 in IDLE -> next cycle StartError=1, FrameDone=1, Busy=0. A valid frame immediately following clears StartError and yields DataValid=1.
5. CNT_WIDTH=2, five consecutive errored frames -> ErrorCount 1,2,3,3,3. Then ClrCount asserted together with a 6th error -> ErrorCount=0.
6. RST=1 after the 4th data sample -> next cycle Busy=0 and all outputs 0. A subsequent full frame 0x5A decodes correctly.
